// File: rtl/fetch_queue.sv
// Fetch stage: PC generator, in-order imem request port and a DEPTH-entry prefetch FIFO.
// Optional FETCH_QUEUE_PERF_EN adds pop and redirect counters as output ports.

module fetch_queue_checker #(
    parameter int CW = 3
) (
    input logic          clk,
    input logic          reset,
    input logic          imem_rvalid,
    input logic          push_s,
    input logic          pop_s,
    input logic          full_s,
    input logic [CW-1:0] in_flight_r
);
    // Every response must pair with an accepted request, and the credit rule must keep the FIFO from overflowing
    a_rvalid_has_request: assert property (@(posedge clk) disable iff (!reset)
        imem_rvalid |-> (in_flight_r != {CW{1'b0}}));
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset)
        (push_s && full_s) |-> pop_s);
endmodule

module fetch_queue #(
    parameter int              N        = 64,
    parameter int              IW       = 32,
    parameter int              DEPTH    = 4,
    parameter logic [N-1:0]    RESET_PC = {N{1'b0}},
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          PCSrc_F,
    input  logic [N-1:0]  PCBranch_F,
    output logic          imem_req_F,
    output logic [N-1:0]  imem_addr_F,
    input  logic          imem_ack_F,
    input  logic          imem_rvalid,
    input  logic [IW-1:0] imem_rdata,
    output logic          inst_valid_D,
    output logic [IW-1:0] inst_D,
    output logic [N-1:0]  inst_pc_D,
    input  logic          inst_ready_D
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_redirects
`endif
);
    localparam int             AW      = $clog2(DEPTH);
    localparam int             CW      = AW + 1;
    localparam logic [N-1:0]   STEP_C  = N'(PC_STEP);
    localparam logic [CW-1:0]  ONE_C   = CW'(1);
    localparam logic [CW-1:0]  FULL_C  = CW'(DEPTH);
    localparam logic [CW:0]    LIMIT_C = (CW+1)'(DEPTH);

    logic [N-1:0]  pc_r;
    logic [N-1:0]  resp_pc_r;
    logic [CW-1:0] in_flight_r;
    logic [CW-1:0] drop_cnt_r;
    logic [CW-1:0] count_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [N-1:0]  mem_pc_r   [DEPTH];
    logic [IW-1:0] mem_inst_r [DEPTH];

    logic          credit_s;
    logic          accept_s;
    logic          drop_s;
    logic          push_s;
    logic          pop_s;
    logic          full_s;
    logic [CW-1:0] in_flight_nxt_s;
    logic [CW-1:0] count_nxt_s;

    // Outstanding requests plus buffered entries may never exceed the FIFO size
    assign credit_s     = ({1'b0, in_flight_r} + {1'b0, count_r}) < LIMIT_C;
    assign imem_req_F   = reset && !PCSrc_F && credit_s;
    assign imem_addr_F  = pc_r;
    assign inst_valid_D = (count_r != {CW{1'b0}});
    assign inst_D       = mem_inst_r[rd_ptr_r];
    assign inst_pc_D    = mem_pc_r[rd_ptr_r];
    assign full_s       = (count_r == FULL_C);

    // Event decode; a redirect voids any push or pop in its cycle
    always_comb begin
        accept_s = imem_req_F && imem_ack_F;
        drop_s   = imem_rvalid && (drop_cnt_r != {CW{1'b0}});
        push_s   = imem_rvalid && !PCSrc_F && (drop_cnt_r == {CW{1'b0}});
        pop_s    = inst_valid_D && inst_ready_D && !PCSrc_F;
    end

    // Next in-flight and occupancy counts
    always_comb begin
        in_flight_nxt_s = in_flight_r;
        count_nxt_s     = count_r;
        case ({accept_s, imem_rvalid})
            2'b10:   in_flight_nxt_s = in_flight_r + ONE_C;
            2'b01:   in_flight_nxt_s = in_flight_r - ONE_C;
            default: in_flight_nxt_s = in_flight_r;
        endcase
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + ONE_C;
            2'b01:   count_nxt_s = count_r - ONE_C;
            default: count_nxt_s = count_r;
        endcase
    end

    // PC, response tracking and FIFO pointer state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r        <= RESET_PC;
            resp_pc_r   <= RESET_PC;
            in_flight_r <= {CW{1'b0}};
            drop_cnt_r  <= {CW{1'b0}};
            count_r     <= {CW{1'b0}};
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
        end else begin
            in_flight_r <= in_flight_nxt_s;
            if (PCSrc_F) begin
                // Responses still owed to the old path must be swallowed
                pc_r       <= PCBranch_F;
                resp_pc_r  <= PCBranch_F;
                drop_cnt_r <= in_flight_r - CW'(imem_rvalid);
                count_r    <= {CW{1'b0}};
                wr_ptr_r   <= {AW{1'b0}};
                rd_ptr_r   <= {AW{1'b0}};
            end else begin
                count_r <= count_nxt_s;
                if (accept_s) begin
                    pc_r <= pc_r + STEP_C;
                end
                if (drop_s) begin
                    drop_cnt_r <= drop_cnt_r - ONE_C;
                end
                if (push_s) begin
                    resp_pc_r <= resp_pc_r + STEP_C;
                    wr_ptr_r  <= wr_ptr_r + AW'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + AW'(1);
                end
            end
        end
    end

    // FIFO storage, written on push only
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_pc_r[wr_ptr_r]   <= resp_pc_r;
            mem_inst_r[wr_ptr_r] <= imem_rdata;
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    // Pop and redirect counters, wrapping at 2^32
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched   <= 32'd0;
            perf_redirects <= 32'd0;
        end else begin
            if (pop_s) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (PCSrc_F) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
        end
    end
`endif

    fetch_queue_checker #(.CW(CW)) u_checker (
        .clk         (clk),
        .reset       (reset),
        .imem_rvalid (imem_rvalid),
        .push_s      (push_s),
        .pop_s       (pop_s),
        .full_s      (full_s),
        .in_flight_r (in_flight_r)
    );
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, backpressure, redirects, PC wrap and async reset.
// Define FETCH_QUEUE_PERF_EN to also check the performance counters.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        PCSrc_F = 1'b0;
    logic [63:0] PCBranch_F = 64'd0;
    logic        imem_req_F;
    logic [63:0] imem_addr_F;
    logic        imem_ack_F = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        inst_valid_D;
    logic [31:0] inst_D;
    logic [63:0] inst_pc_D;
    logic        inst_ready_D = 1'b0;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_redirects;
`endif

    int          checks = 0;
    int          errors = 0;
    logic        mem_on = 1'b0;
    logic [63:0] mem_q [$];

    fetch_queue dut (
        .clk          (clk),
        .reset        (reset),
        .PCSrc_F      (PCSrc_F),
        .PCBranch_F   (PCBranch_F),
        .imem_req_F   (imem_req_F),
        .imem_addr_F  (imem_addr_F),
        .imem_ack_F   (imem_ack_F),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .inst_valid_D (inst_valid_D),
        .inst_D       (inst_D),
        .inst_pc_D    (inst_pc_D),
        .inst_ready_D (inst_ready_D)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_redirects (perf_redirects)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mem_data(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: memory captures accepted requests, then answers one cycle later in order
    task automatic tick();
        logic [63:0] a;
        @(negedge clk);
        if (imem_req_F && imem_ack_F) mem_q.push_back(imem_addr_F);
        @(posedge clk);
        #1;
        if (mem_on && mem_q.size() > 0) begin
            a = mem_q.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = mem_data(a);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'd0;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        imem_rvalid = 1'b0;
        imem_ack_F = 1'b0;
        inst_ready_D = 1'b0;
        PCSrc_F = 1'b0;
        mem_on = 1'b0;
        mem_q.delete();
        #1;
        check("rst_req", {63'd0, imem_req_F}, 64'd0);
        check("rst_valid", {63'd0, inst_valid_D}, 64'd0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_addr", imem_addr_F, 64'd0);
        check("rst_req_after", {63'd0, imem_req_F}, 64'd1);
`ifdef FETCH_QUEUE_PERF_EN
        check("rst_perf_fetched", {32'd0, perf_fetched}, 64'd0);
        check("rst_perf_redirects", {32'd0, perf_redirects}, 64'd0);
`endif
    endtask

    initial begin
        // Reset state
        do_reset();

        // Streaming
        imem_ack_F = 1'b1; inst_ready_D = 1'b1; mem_on = 1'b1;
        tick();
        check("stream_latency", {63'd0, inst_valid_D}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("stream_valid", {63'd0, inst_valid_D}, 64'd1);
            check("stream_pc", inst_pc_D, 64'(4 * i));
            check("stream_inst", {32'd0, inst_D}, {32'd0, mem_data(64'(4 * i))});
        end

        // Async reset mid-stream
        do_reset();

        // Backpressure
        imem_ack_F = 1'b1; inst_ready_D = 1'b0; mem_on = 1'b1;
        repeat (5) tick();
        check("bp_req_stop", {63'd0, imem_req_F}, 64'd0);
        check("bp_addr", imem_addr_F, 64'd16);
        check("bp_head", inst_pc_D, 64'd0);
        repeat (2) tick();
        check("bp_req_hold", {63'd0, imem_req_F}, 64'd0);
        check("bp_head_hold", inst_pc_D, 64'd0);
        inst_ready_D = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("bp_pop_pc", inst_pc_D, 64'(4 * i));
        end

        // Redirect with three requests in flight
        do_reset();
        imem_ack_F = 1'b1; inst_ready_D = 1'b1; mem_on = 1'b0;
        repeat (3) tick();
        imem_ack_F = 1'b0;
        check("rd_addr_pre", imem_addr_F, 64'd12);
        check("rd_req_pre", {63'd0, imem_req_F}, 64'd1);
        PCSrc_F = 1'b1; PCBranch_F = 64'h100;
        #1;
        check("rd_req_blocked", {63'd0, imem_req_F}, 64'd0);
        tick();
        PCSrc_F = 1'b0; mem_on = 1'b1; imem_ack_F = 1'b1;
        check("rd_flushed", {63'd0, inst_valid_D}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rd_dropping", {63'd0, inst_valid_D}, 64'd0);
        end
        tick();
        check("rd_first_pc", inst_pc_D, 64'h100);
        check("rd_first_inst", {32'd0, inst_D}, {32'd0, mem_data(64'h100)});
        tick();
        check("rd_second_pc", inst_pc_D, 64'h104);

        // Redirect coinciding with a response and a pop
        do_reset();
        imem_ack_F = 1'b1; inst_ready_D = 1'b0; mem_on = 1'b0;
        repeat (3) tick();
        imem_ack_F = 1'b0; mem_on = 1'b1;
        repeat (2) tick();
        check("co_head_valid", {63'd0, inst_valid_D}, 64'd1);
        check("co_head_pc", inst_pc_D, 64'd0);
        inst_ready_D = 1'b1; PCSrc_F = 1'b1; PCBranch_F = 64'h200;
        tick();
        PCSrc_F = 1'b0; imem_ack_F = 1'b1;
        check("co_flushed", {63'd0, inst_valid_D}, 64'd0);
        tick();
        check("co_dropping", {63'd0, inst_valid_D}, 64'd0);
        tick();
        check("co_first_pc", inst_pc_D, 64'h200);
        check("co_first_inst", {32'd0, inst_D}, {32'd0, mem_data(64'h200)});
        tick();
        check("co_second_pc", inst_pc_D, 64'h204);

        // PC wrap at 2^64
        do_reset();
        imem_ack_F = 1'b1; inst_ready_D = 1'b1; mem_on = 1'b1;
        PCSrc_F = 1'b1; PCBranch_F = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        PCSrc_F = 1'b0;
        check("wrap_addr_top", imem_addr_F, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        check("wrap_addr_zero", imem_addr_F, 64'd0);
        tick();
        check("wrap_pc_top", inst_pc_D, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        check("wrap_pc_zero", inst_pc_D, 64'd0);

        do_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
